// File: rtl/regfile_2r1w.sv
// Two-read, one-write register file with registered read ports and write-first bypass.
// Entry 0 can be hardwired to zero through ZERO_REG.
module regfile_2r1w #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int ZERO_REG   = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re1,
  input  logic [ADDR_WIDTH-1:0] raddr1,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  rvalid1,
  input  logic                  re2,
  input  logic [ADDR_WIDTH-1:0] raddr2,
  output logic [DATA_WIDTH-1:0] rdata2,
  output logic                  rvalid2
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  wr_ok;
  logic [DATA_WIDTH-1:0] rd1_p0, rd2_p0;
  logic [DATA_WIDTH-1:0] rd1_p1, rd2_p1;
  logic                  vld1_p1, vld2_p1;

  // A write to the hardwired zero entry is dropped, so entry 0 stays at its reset value.
  assign wr_ok = we && !(ZERO_REG != 0 && waddr == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_ok) begin
      mem[waddr] <= wdata;
    end
  end

  // Stage p0: array lookup, with the same-edge write forwarded ahead of the stored entry.
  always_comb begin
    rd1_p0 = mem[raddr1];
    if (wr_ok && waddr == raddr1) rd1_p0 = wdata;
    if (ZERO_REG != 0 && raddr1 == '0) rd1_p0 = '0;
    rd2_p0 = mem[raddr2];
    if (wr_ok && waddr == raddr2) rd2_p0 = wdata;
    if (ZERO_REG != 0 && raddr2 == '0) rd2_p0 = '0;
  end

  // Stage p1: registered outputs; data is forced to zero whenever its port was not enabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd1_p1  <= '0;
      rd2_p1  <= '0;
      vld1_p1 <= 1'b0;
      vld2_p1 <= 1'b0;
    end else begin
      rd1_p1  <= re1 ? rd1_p0 : '0;
      rd2_p1  <= re2 ? rd2_p0 : '0;
      vld1_p1 <= re1;
      vld2_p1 <= re2;
    end
  end

  assign rdata1  = rd1_p1;
  assign rdata2  = rd2_p1;
  assign rvalid1 = vld1_p1;
  assign rvalid2 = vld2_p1;

endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed bench driving three configurations of regfile_2r1w from one shared stimulus:
// default 8-bit, 8-bit with hardwired zero entry, and 32-bit.
module tb_regfile_2r1w;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [2:0]  waddr;
  logic [31:0] wdata;
  logic        re1, re2;
  logic [2:0]  raddr1, raddr2;

  logic [7:0]  a_rdata1, a_rdata2, z_rdata1, z_rdata2;
  logic        a_rvalid1, a_rvalid2, z_rvalid1, z_rvalid2;
  logic [31:0] w_rdata1, w_rdata2;
  logic        w_rvalid1, w_rvalid2;

  int vectors = 0;
  int errs    = 0;

  always #5 clk = ~clk;

  regfile_2r1w #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .ZERO_REG(0)) u_a (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata[7:0]),
    .re1(re1), .raddr1(raddr1), .rdata1(a_rdata1), .rvalid1(a_rvalid1),
    .re2(re2), .raddr2(raddr2), .rdata2(a_rdata2), .rvalid2(a_rvalid2)
  );

  regfile_2r1w #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .ZERO_REG(1)) u_z (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata[7:0]),
    .re1(re1), .raddr1(raddr1), .rdata1(z_rdata1), .rvalid1(z_rvalid1),
    .re2(re2), .raddr2(raddr2), .rdata2(z_rdata2), .rvalid2(z_rvalid2)
  );

  regfile_2r1w #(.DATA_WIDTH(32), .ADDR_WIDTH(3), .ZERO_REG(0)) u_w (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .re1(re1), .raddr1(raddr1), .rdata1(w_rdata1), .rvalid1(w_rvalid1),
    .re2(re2), .raddr2(raddr2), .rdata2(w_rdata2), .rvalid2(w_rvalid2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
    re1 = 1'b0; raddr1 = '0; re2 = 1'b0; raddr2 = '0;
    cyc();
    cyc();
    check("rst_a_rdata1",  {24'h0, a_rdata1}, 32'h0);
    check("rst_a_rdata2",  {24'h0, a_rdata2}, 32'h0);
    check("rst_a_rvalid1", {31'h0, a_rvalid1}, 32'h0);
    check("rst_a_rvalid2", {31'h0, a_rvalid2}, 32'h0);

    // first edge out of reset: read unwritten entry 5 and write entry 3
    reset = 1'b0; re1 = 1'b1; raddr1 = 3'd5; we = 1'b1; waddr = 3'd3; wdata = 32'h0000_00A5;
    cyc();
    check("unwritten_rdata1", {24'h0, a_rdata1}, 32'h00);
    check("unwritten_rvalid1", {31'h0, a_rvalid1}, 32'h1);

    // dual read of the same address
    we = 1'b0; re1 = 1'b1; raddr1 = 3'd3; re2 = 1'b1; raddr2 = 3'd3;
    cyc();
    check("dual_rdata1",  {24'h0, a_rdata1}, 32'hA5);
    check("dual_rdata2",  {24'h0, a_rdata2}, 32'hA5);
    check("dual_rvalid1", {31'h0, a_rvalid1}, 32'h1);
    check("dual_rvalid2", {31'h0, a_rvalid2}, 32'h1);
    check("dual_w_rdata1", w_rdata1, 32'h0000_00A5);

    // idle read ports right after valid reads; preload entry 2
    we = 1'b1; waddr = 3'd2; wdata = 32'h11; re1 = 1'b0; re2 = 1'b0;
    cyc();
    check("idle_rdata1",  {24'h0, a_rdata1}, 32'h0);
    check("idle_rvalid1", {31'h0, a_rvalid1}, 32'h0);
    check("idle_rdata2",  {24'h0, a_rdata2}, 32'h0);

    // write-first bypass on entry 2
    we = 1'b1; waddr = 3'd2; wdata = 32'h22; re1 = 1'b1; raddr1 = 3'd2;
    cyc();
    check("bypass_rdata1", {24'h0, a_rdata1}, 32'h22);
    we = 1'b0;
    cyc();
    check("after_bypass_rdata1", {24'h0, a_rdata1}, 32'h22);

    // writes to entry 0: dropped only when ZERO_REG=1
    we = 1'b1; waddr = 3'd0; wdata = 32'hFF; re1 = 1'b0; re2 = 1'b1; raddr2 = 3'd0;
    cyc();
    check("zr_bypass_rdata2", {24'h0, z_rdata2}, 32'h00);
    check("zr_bypass_rvalid2", {31'h0, z_rvalid2}, 32'h1);
    check("nz_bypass_rdata2", {24'h0, a_rdata2}, 32'hFF);
    we = 1'b0;
    cyc();
    check("zr_read0_rdata2", {24'h0, z_rdata2}, 32'h00);
    check("nz_read0_rdata2", {24'h0, a_rdata2}, 32'hFF);

    // full-width data, then reset concurrent with a read and a write
    we = 1'b1; waddr = 3'd7; wdata = 32'hDEAD_BEEF; re2 = 1'b0;
    cyc();
    we = 1'b0; re1 = 1'b1; raddr1 = 3'd7;
    cyc();
    check("wide_rdata1", w_rdata1, 32'hDEAD_BEEF);
    check("narrow_rdata1", {24'h0, a_rdata1}, 32'hEF);
    reset = 1'b1; re1 = 1'b1; raddr1 = 3'd7; we = 1'b1; waddr = 3'd4; wdata = 32'h55;
    cyc();
    check("rst_dom_rdata1",  w_rdata1, 32'h0);
    check("rst_dom_rvalid1", {31'h0, w_rvalid1}, 32'h0);
    reset = 1'b0; we = 1'b0; re1 = 1'b1; raddr1 = 3'd7; re2 = 1'b1; raddr2 = 3'd4;
    cyc();
    check("post_rst_rdata1",  w_rdata1, 32'h0);
    check("post_rst_rvalid1", {31'h0, w_rvalid1}, 32'h1);
    check("lost_write_rdata2", w_rdata2, 32'h0);
    check("post_rst_a_rdata1", {24'h0, a_rdata1}, 32'h0);

    // independent ports: one bypasses the write, the other reads a cleared entry
    we = 1'b1; waddr = 3'd1; wdata = 32'h3C; re1 = 1'b1; raddr1 = 3'd2; re2 = 1'b1; raddr2 = 3'd1;
    cyc();
    check("indep_rdata1", {24'h0, a_rdata1}, 32'h00);
    check("indep_rdata2", {24'h0, a_rdata2}, 32'h3C);
    check("indep_z_rdata2", {24'h0, z_rdata2}, 32'h3C);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/regfile_2r1w.md
REGFILE_2R1W -- requirements
Module: regfile_2r1w

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, entry width in bits; legal range 8..32.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 3, address width; depth = 2**ADDR_WIDTH entries.
REQ-003 The block SHALL have parameter ZERO_REG, default 0; when 1, entry 0 is hardwired to zero.
REQ-004 The block SHALL have one clock; reset is synchronous and active-high.
REQ-005 The ports SHALL be:
- clk  input  1  clock; all state updates on its rising edge.
- reset  input  1  synchronous active-high reset.
- we  input  1  write enable, write port 1.
- waddr  input  ADDR_WIDTH  write address.
- wdata  input  DATA_WIDTH  write data.
- re1  input  1  read enable, read port 1.
- raddr1  input  ADDR_WIDTH  read address, port 1.
- rdata1  output  DATA_WIDTH  registered read data, port 1.
- rvalid1  output  1  rdata1 valid, port 1.
- re2  input  1  read enable, read port 2.
- raddr2  input  ADDR_WIDTH  read address, port 2.
- rdata2  output  DATA_WIDTH  registered read data, port 2.
- rvalid2  output  1  rdata2 valid, port 2.

Function
REQ-006 A write SHALL occur at the rising clk edge when we=1 and reset=0: mem[waddr] <= wdata.
REQ-007 When ZERO_REG=1, writes to address 0 SHALL be discarded; entry 0 SHALL always read 0.
REQ-008 Each read port SHALL have 1-cycle latency: re sampled high at edge N -> rdata/rvalid valid after edge N.
REQ-009 rvalidN SHALL equal the value of reN sampled at the previous edge (0 after reset).
REQ-010 When reN sampled low, rdataN SHALL be driven to 0 and rvalidN to 0 at that edge.
REQ-011 Write priority: if we=1 and waddr==raddrN at the same edge, port N SHALL return wdata (write-first bypass), not the old entry.
REQ-012 Bypass SHALL NOT apply when ZERO_REG=1 and address is 0; port returns 0.
REQ-013 Both read ports and the write port SHALL operate independently in the same cycle; both reads of the same address SHALL return identical data.
REQ-014 Reads SHALL NOT modify storage; unwritten entries SHALL read 0 after reset.
REQ-015 Addresses SHALL be full-range; no out-of-range condition exists.
REQ-016 Read data SHALL be exactly DATA_WIDTH bits, with no sign-extension or truncation.

Reset
REQ-017 With reset=1 at an edge, all entries, rdata1, rdata2, rvalid1, rvalid2 SHALL become 0.
REQ-018 reset SHALL dominate we/re1/re2 at the same edge; a concurrent write is lost, reads return 0 with rvalid=0.
REQ-019 First write SHALL be accepted at the first edge with reset=0.

Verification
REQ-020 Reset, then re1=1 raddr1=5 -> next cycle rdata1=0x00, rvalid1=1.
REQ-021 we=1 waddr=3 wdata=0xA5; next cycle re1=1 raddr1=3, re2=1 raddr2=3 -> rdata1=rdata2=0xA5, both rvalid=1.
REQ-022 Entry 2 holds 0x11; same edge we=1 waddr=2 wdata=0x22 and re1=1 raddr1=2 -> rdata1=0x22 (bypass); following read -> 0x22.
REQ-023 ZERO_REG=1: we=1 waddr=0 wdata=0xFF with re2=1 raddr2=0 -> rdata2=0x00; later read of 0 -> 0x00.
REQ-024 DATA_WIDTH=32: write 0xDEADBEEF to addr 7, then reset=1 concurrent with re1=1 raddr1=7 -> rdata1=0, rvalid1=0; subsequent read of 7 -> 0x00000000.
REQ-025 re1=0 for one cycle after a valid read -> rdata1=0, rvalid1=0 that cycle.
